// File: rtl/punc_mem_arbiter.sv
// rtl/punc_mem_arbiter.sv - two-master (cpu/debug) arbiter for an async-read, sync-write memory
// Optional grant locking for multi-access sequences is enabled by defining PUNC_ARB_LOCK_EN.
module punc_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
`ifdef PUNC_ARB_LOCK_EN
  input  logic              cpu_lock,
  input  logic              dbg_lock,
`endif
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data
);

  typedef enum logic [1:0] {ARB, LOCK_CPU, LOCK_DBG} state_t;

  localparam logic WIN_DBG = 1'b1;
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  state_t              state, state_nxt;
  logic                last_winner;
  logic [3:0]          lock_cnt, lock_cnt_nxt;
  logic                cpu_lk, dbg_lk;
  logic                gnt_any, rd_gnt, win_we, win_lock;
  logic [ADDR_W-1:0]   win_addr, r_addr_q;
  logic [DATA_W-1:0]   win_wdata;

`ifdef PUNC_ARB_LOCK_EN
  assign cpu_lk = cpu_lock;
  assign dbg_lk = dbg_lock;
`else
  // Without locking the FSM can never leave ARB.
  assign cpu_lk = 1'b0;
  assign dbg_lk = 1'b0;
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (cpu_req && dbg_req) begin
            if (last_winner == WIN_DBG) cpu_gnt = 1'b1;
            else                        dbg_gnt = 1'b1;
          end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
          end
        end
        LOCK_CPU: cpu_gnt = cpu_req;
        LOCK_DBG: dbg_gnt = dbg_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_any    = cpu_gnt | dbg_gnt;
    win_we     = dbg_gnt ? dbg_we    : cpu_we;
    win_lock   = dbg_gnt ? dbg_lk    : cpu_lk;
    win_addr   = dbg_gnt ? dbg_addr  : cpu_addr;
    win_wdata  = dbg_gnt ? dbg_wdata : cpu_wdata;
    rd_gnt     = gnt_any & ~win_we;
    mem_w_en   = gnt_any & win_we;
    mem_w_addr = win_addr;
    mem_w_data = win_wdata;
    mem_r_addr = rd_gnt ? win_addr : r_addr_q;
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ARB: begin
        if (gnt_any && win_lock && (LOCK_MAX_C > 4'd1)) begin
          state_nxt    = dbg_gnt ? LOCK_DBG : LOCK_CPU;
          lock_cnt_nxt = 4'd1;
        end
      end
      LOCK_CPU, LOCK_DBG: begin
        if (gnt_any) begin
          if (!win_lock) begin
            state_nxt = ARB;
          end else begin
            lock_cnt_nxt = lock_cnt + 4'd1;
            // Forced release: the holder is already last_winner, so the other side wins next.
            if (lock_cnt + 4'd1 == LOCK_MAX_C) state_nxt = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      last_winner <= WIN_DBG;
      lock_cnt    <= 4'd0;
      cpu_rvalid  <= 1'b0;
      dbg_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
      r_addr_q    <= '0;
    end else begin
      state      <= state_nxt;
      lock_cnt   <= lock_cnt_nxt;
      cpu_rvalid <= rd_gnt & cpu_gnt;
      dbg_rvalid <= rd_gnt & dbg_gnt;
      if (gnt_any)           last_winner <= dbg_gnt;
      if (rd_gnt)            r_addr_q    <= win_addr;
      if (rd_gnt && cpu_gnt) cpu_rdata   <= mem_r_data;
      if (rd_gnt && dbg_gnt) dbg_rdata   <= mem_r_data;
    end
  end

endmodule

// File: doc/punc_mem_arbiter.md
PUNC_MEM_ARBITER -- requirements
Module: punc_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, memory address width.
REQ-002 Parameter: DATA_W, 16, memory data width.
REQ-003 Parameter: LOCK_MAX, 4, maximum consecutive locked grants (range 1..15).
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Ports: cpu_req / dbg_req  input  1  access request from the control unit / debug loader.
REQ-007 Ports: cpu_we / dbg_we  input  1  1 = write, 0 = read.
REQ-008 Ports: cpu_addr / dbg_addr  input  ADDR_W  access address.
REQ-009 Ports: cpu_wdata / dbg_wdata  input  DATA_W  write data.
REQ-010 Ports: cpu_lock / dbg_lock  input  1  hold grant for the next access (e.g. LDI/STI pointer then data); present only with the configuration macro.
REQ-011 Ports: cpu_gnt / dbg_gnt  output  1  combinational grant, same cycle as request.
REQ-012 Ports: cpu_rvalid / dbg_rvalid  output  1  one-cycle pulse: read data valid.
REQ-013 Ports: cpu_rdata / dbg_rdata  output  DATA_W  registered read data.
REQ-014 Ports: mem_r_addr  output  ADDR_W  address to the asynchronous-read memory.
REQ-015 Port: mem_r_data  input  DATA_W  memory read data, valid in the same cycle.
REQ-016 Ports: mem_w_en  output  1; mem_w_addr  output  ADDR_W; mem_w_data  output  DATA_W  synchronous memory write port.

Function
REQ-017 At most one of cpu_gnt and dbg_gnt SHALL be high in any cycle; a grant SHALL only be asserted when the matching req is high.
REQ-018 FSM states: ARB, LOCK_CPU, LOCK_DBG.
REQ-019 ARB, one requester: that requester SHALL be granted.
REQ-020 ARB, both requesting: the requester not recorded in last_winner SHALL be granted.
REQ-021 last_winner SHALL update on every granted cycle.
REQ-022 Granted write: mem_w_en=1, with mem_w_addr/mem_w_data taken from the winner in the same cycle.
REQ-023 Granted read: mem_r_addr SHALL equal the winner's address; mem_r_data SHALL be registered into the winner's rdata; the winner's rvalid SHALL pulse on the following cycle (latency 1).
REQ-024 With no grant: mem_w_en=0, mem_r_addr holds its last value, and both rdata outputs hold their values.
REQ-025 Granted with lock=1 in ARB: next state SHALL be LOCK_<winner> and lock_cnt SHALL be set to 1.
REQ-026 LOCK_X: X is granted whenever it requests, and the other requester is never granted.
REQ-027 LOCK_X, each X grant with lock=1: lock_cnt SHALL increment.
REQ-028 LOCK_X: the FSM SHALL return to ARB when X is granted with lock=0, or when lock_cnt reaches LOCK_MAX (forced release), whichever comes first.
REQ-029 Forced release: last_winner SHALL equal X, so the other requester wins the next contention.
REQ-030 LOCK_X with X not requesting: the state SHALL hold and lock_cnt SHALL not change.
REQ-031 Lock and we are independent: a locked write followed by an unlocked read is legal.

Reset
REQ-032 rst SHALL force: state=ARB, last_winner=dbg (CPU wins the first contention), lock_cnt=0.
REQ-033 rst SHALL force both rvalid=0, both rdata=0, and mem_r_addr=0.
REQ-034 During rst: all grants=0 and mem_w_en=0.
REQ-035 An rvalid due in the cycle after rst is asserted SHALL be suppressed.
REQ-036 rst in LOCK_X SHALL abandon the lock with no further grant to X.

Configuration
REQ-037 Macro PUNC_ARB_LOCK_EN: defined -> lock ports, LOCK_* states and lock_cnt exist as specified.
REQ-038 PUNC_ARB_LOCK_EN undefined: lock ports are absent, the FSM stays in ARB permanently, and arbitration is pure round-robin.

Verification
REQ-039 Reset, then cpu_req read addr 0x0003 with mem[3]=0xBEEF -> cpu_gnt same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF.
REQ-040 Both requesting continuously for 6 cycles -> grants alternate cpu,dbg,cpu,dbg,cpu,dbg.
REQ-041 dbg write addr 0x0010 data 0x1234 -> mem_w_en=1 that cycle; a later cpu read of 0x0010 returns 0x1234.
REQ-042 cpu locks (lock=1) with dbg requesting throughout, LOCK_MAX=4 -> 4 consecutive cpu grants, forced release, then dbg granted.
REQ-043 rst asserted in LOCK_DBG during the read grant cycle -> no dbg_rvalid the next cycle; cpu granted first afterwards.
REQ-044 Without PUNC_ARB_LOCK_EN, cpu_lock stimulus omitted, both requesting -> strict alternation, never two consecutive grants to the same requester.
